// File: rtl/sram_arb.sv
// Two-port arbiter in front of a single-transfer SRAM controller.
// It selects a requester, latches its command, runs one handshake with the controller, then acknowledges.
module sram_arb #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [17:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [17:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        ctrl_start_n,
  output logic        ctrl_rw,
  output logic [17:0] ctrl_addr,
  output logic [15:0] ctrl_wdata,
  input  logic        ctrl_ready,
  input  logic [15:0] ctrl_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   winner;

  // A tie goes to port 0 in fixed mode, otherwise to whichever port was not served last.
  always_comb begin
    winner = m1_req;
    if (m0_req && m1_req) begin
      winner = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      ctrl_start_n <= 1'b1;
      ctrl_rw      <= 1'b1;
      ctrl_addr    <= '0;
      ctrl_wdata   <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= '0;
      m1_rdata     <= '0;
    end else begin
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      ctrl_start_n <= 1'b1;
      case (state)
        IDLE: begin
          if (ctrl_ready && (m0_req || m1_req)) begin
            grant        <= winner;
            ctrl_rw      <= winner ? m1_rw    : m0_rw;
            ctrl_addr    <= winner ? m1_addr  : m0_addr;
            ctrl_wdata   <= winner ? m1_wdata : m0_wdata;
            ctrl_start_n <= 1'b0;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (ctrl_ready) begin
            if (ctrl_rw) begin
              if (grant) begin
                m1_rdata <= ctrl_rdata;
              end else begin
                m0_rdata <= ctrl_rdata;
              end
            end
            m0_ack <= ~grant;
            m1_ack <= grant;
            state  <= DONE;
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: a round-robin and a fixed-priority instance share the requester inputs,
// each talking to its own small behavioural SRAM controller.
module tb_sram_arb;

  logic        clk;
  logic        reset_n;
  logic        m0_req;
  logic        m0_rw;
  logic [17:0] m0_addr;
  logic [15:0] m0_wdata;
  logic        m1_req;
  logic        m1_rw;
  logic [17:0] m1_addr;
  logic [15:0] m1_wdata;
  logic        ready_block;
  int          cyc;
  int          assertions;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic        m0_ack;
    logic        m1_ack;
    logic [15:0] m0_rdata;
    logic [15:0] m1_rdata;
    logic        ctrl_start_n;
    logic        ctrl_rw;
    logic [17:0] ctrl_addr;
    logic [15:0] ctrl_wdata;
    logic        ctrl_ready;
    logic [15:0] ctrl_rdata;
    logic        busy;
    logic        model_ready;
    logic        lat_rw;
    logic [17:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [15:0] mem [16];
    int          wr_count;
    logic [17:0] last_wr_addr;
    logic [15:0] last_wr_data;
    int          ack_port_q[$];
    int          ack_cyc_q[$];

    sram_arb #(.PRIO_FIXED(g)) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .m0_req       (m0_req),
      .m0_rw        (m0_rw),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_ack       (m0_ack),
      .m0_rdata     (m0_rdata),
      .m1_req       (m1_req),
      .m1_rw        (m1_rw),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_ack       (m1_ack),
      .m1_rdata     (m1_rdata),
      .ctrl_start_n (ctrl_start_n),
      .ctrl_rw      (ctrl_rw),
      .ctrl_addr    (ctrl_addr),
      .ctrl_wdata   (ctrl_wdata),
      .ctrl_ready   (ctrl_ready),
      .ctrl_rdata   (ctrl_rdata)
    );

    assign ctrl_ready = model_ready && !ready_block;

    // Controller: drops ready on the start edge, performs the access one cycle later and raises ready again.
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        busy         <= 1'b0;
        model_ready  <= 1'b1;
        lat_rw       <= 1'b1;
        lat_addr     <= '0;
        lat_wdata    <= '0;
        ctrl_rdata   <= '0;
        wr_count     <= 0;
        last_wr_addr <= '0;
        last_wr_data <= '0;
        for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (!busy && !ctrl_start_n) begin
        busy        <= 1'b1;
        model_ready <= 1'b0;
        lat_rw      <= ctrl_rw;
        lat_addr    <= ctrl_addr;
        lat_wdata   <= ctrl_wdata;
      end else if (busy) begin
        busy        <= 1'b0;
        model_ready <= 1'b1;
        if (lat_rw) begin
          ctrl_rdata <= mem[lat_addr[3:0]];
        end else begin
          mem[lat_addr[3:0]] <= lat_wdata;
          wr_count           <= wr_count + 1;
          last_wr_addr       <= lat_addr;
          last_wr_data       <= lat_wdata;
        end
      end
    end

    always @(negedge clk) begin
      if (m0_ack) begin
        ack_port_q.push_back(0);
        ack_cyc_q.push_back(cyc);
      end
      if (m1_ack) begin
        ack_port_q.push_back(1);
        ack_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic rw,
                               input logic [17:0] addr, input logic [15:0] wdata);
    if (port == 0) begin
      m0_req = req; m0_rw = rw; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_rw = rw; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  function automatic logic ack_of(input int port);
    return (port == 0) ? gen_dut[0].m0_ack : gen_dut[0].m1_ack;
  endfunction

  function automatic int q_size(input int inst);
    return (inst == 0) ? gen_dut[0].ack_port_q.size() : gen_dut[1].ack_port_q.size();
  endfunction

  function automatic int q_port(input int inst, input int idx);
    if (idx >= q_size(inst)) return -1;
    return (inst == 0) ? gen_dut[0].ack_port_q[idx] : gen_dut[1].ack_port_q[idx];
  endfunction

  function automatic int q_cyc(input int inst, input int idx);
    if (idx >= q_size(inst)) return -1;
    return (inst == 0) ? gen_dut[0].ack_cyc_q[idx] : gen_dut[1].ack_cyc_q[idx];
  endfunction

  // Counts rising edges until the round-robin instance acks the given port; -1 on timeout.
  task automatic wait_ack(input int port, output int cycles, output int starts);
    cycles = -1;
    starts = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (!gen_dut[0].ctrl_start_n) starts++;
      if (ack_of(port)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_queue(input int inst, input int target, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (q_size(inst) >= target) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int cycles;
    int starts;
    int base0;
    int base1;
    int bad;
    int wr_base;

    assertions  = 0;
    failures    = 0;
    reset_n     = 1'b0;
    ready_block = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 18'h0, 16'h0);
    applyStimulus(1, 1'b0, 1'b0, 18'h0, 16'h0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset start_n",  32'(gen_dut[0].ctrl_start_n), 32'd1);
    checkOutput("reset ctrl_rw",  32'(gen_dut[0].ctrl_rw),      32'd1);
    checkOutput("reset ctrl_addr",  32'(gen_dut[0].ctrl_addr),  32'd0);
    checkOutput("reset ctrl_wdata", 32'(gen_dut[0].ctrl_wdata), 32'd0);
    checkOutput("reset acks", 32'({gen_dut[0].m0_ack, gen_dut[0].m1_ack}), 32'd0);
    checkOutput("reset rdata", 32'({gen_dut[0].m0_rdata, gen_dut[0].m1_rdata}), 32'd0);
    checkOutput("reset fixed start_n", 32'(gen_dut[1].ctrl_start_n), 32'd1);
    reset_n = 1'b1;

    $display("[TB] port-0 write then read of 0x00012");
    applyStimulus(0, 1'b1, 1'b0, 18'h00012, 16'hBEEF);
    wait_ack(0, cycles, starts);
    checkOutput("write ack latency", 32'(cycles), 32'd4);
    checkOutput("write start pulses", 32'(starts), 32'd1);
    applyStimulus(0, 1'b1, 1'b1, 18'h00012, 16'h0000);
    wait_ack(0, cycles, starts);
    checkOutput("held req read latency", 32'(cycles), 32'd5);
    checkOutput("read start pulses", 32'(starts), 32'd1);
    checkOutput("m0_rdata after read", 32'(gen_dut[0].m0_rdata), 32'h0000BEEF);
    checkOutput("m1_rdata untouched", 32'(gen_dut[0].m1_rdata), 32'd0);
    checkOutput("ctrl write seen", 32'(gen_dut[0].last_wr_addr), 32'h00012);
    applyStimulus(0, 1'b0, 1'b1, 18'h00012, 16'h0000);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] both ports requesting continuously");
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    base0 = q_size(0);
    base1 = q_size(1);
    applyStimulus(0, 1'b1, 1'b0, 18'h00005, 16'h1111);
    applyStimulus(1, 1'b1, 1'b0, 18'h00006, 16'h2222);
    wait_queue(1, base1 + 3, "fixed three acks");
    m0_req = 1'b0;
    wait_queue(1, base1 + 4, "fixed fourth ack");
    m1_req = 1'b0;
    checkOutput("rr ack count", 32'(q_size(0) - base0), 32'd4);
    checkOutput("rr grant 1", 32'(q_port(0, base0)),     32'd0);
    checkOutput("rr grant 2", 32'(q_port(0, base0 + 1)), 32'd1);
    checkOutput("rr grant 3", 32'(q_port(0, base0 + 2)), 32'd0);
    checkOutput("rr grant 4", 32'(q_port(0, base0 + 3)), 32'd1);
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("rr ack spacing %0d", i),
                  32'(q_cyc(0, base0 + i) - q_cyc(0, base0 + i - 1)), 32'd5);
    end
    checkOutput("fixed grant 1", 32'(q_port(1, base1)),     32'd0);
    checkOutput("fixed grant 2", 32'(q_port(1, base1 + 1)), 32'd0);
    checkOutput("fixed grant 3", 32'(q_port(1, base1 + 2)), 32'd0);
    checkOutput("fixed grant after drop", 32'(q_port(1, base1 + 3)), 32'd1);
    checkOutput("fixed spacing", 32'(q_cyc(1, base1 + 1) - q_cyc(1, base1)), 32'd5);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] controller not ready for 10 cycles");
    ready_block = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 18'h00007, 16'h7777);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!gen_dut[0].ctrl_start_n || gen_dut[0].m0_ack || gen_dut[0].m1_ack) bad++;
    end
    checkOutput("stalled cycles with activity", 32'(bad), 32'd0);
    ready_block = 1'b0;
    @(posedge clk); #1;
    checkOutput("start on first ready", 32'(gen_dut[0].ctrl_start_n), 32'd0);
    wait_ack(1, cycles, starts);
    checkOutput("stalled transfer ack latency", 32'(cycles), 32'd3);
    applyStimulus(1, 1'b0, 1'b0, 18'h00007, 16'h7777);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] reset during port-1 read");
    applyStimulus(0, 1'b1, 1'b0, 18'h00009, 16'hCAFE);
    wait_ack(0, cycles, starts);
    checkOutput("cafe write latency", 32'(cycles), 32'd4);
    applyStimulus(0, 1'b0, 1'b0, 18'h00009, 16'hCAFE);
    applyStimulus(1, 1'b1, 1'b1, 18'h00009, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("port-1 read in wait", 32'(gen_dut[0].ctrl_addr), 32'h00009);
    base0 = q_size(0);
    reset_n = 1'b0;
    #2;
    checkOutput("reset start_n mid", 32'(gen_dut[0].ctrl_start_n), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("no m1_ack after reset", 32'(q_size(0) - base0), 32'd0);
    checkOutput("m1_rdata after reset", 32'(gen_dut[0].m1_rdata), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 18'h00003, 16'h3333);
    applyStimulus(1, 1'b1, 1'b0, 18'h00004, 16'h4444);
    reset_n = 1'b1;
    wait_queue(0, base0 + 1, "post-reset tie ack");
    applyStimulus(0, 1'b0, 1'b0, 18'h00003, 16'h3333);
    applyStimulus(1, 1'b0, 1'b0, 18'h00004, 16'h4444);
    checkOutput("post-reset tie winner", 32'(q_port(0, base0)), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] port-1 write with req dropped after accept");
    wr_base = gen_dut[0].wr_count;
    base0   = q_size(0);
    applyStimulus(1, 1'b1, 1'b0, 18'h3FFFF, 16'h1234);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 1'b1, 18'h00000, 16'h0000);
    wait_ack(1, cycles, starts);
    checkOutput("dropped req ack latency", 32'(cycles), 32'd3);
    checkOutput("stable ctrl_addr", 32'(gen_dut[0].ctrl_addr), 32'h3FFFF);
    checkOutput("stable ctrl_wdata", 32'(gen_dut[0].ctrl_wdata), 32'h1234);
    checkOutput("stable ctrl_rw", 32'(gen_dut[0].ctrl_rw), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("single m1_ack", 32'(q_size(0) - base0), 32'd1);
    checkOutput("ack went to port 1", 32'(q_port(0, base0)), 32'd1);
    checkOutput("controller write count", 32'(gen_dut[0].wr_count - wr_base), 32'd1);
    checkOutput("controller write addr", 32'(gen_dut[0].last_wr_addr), 32'h3FFFF);
    checkOutput("controller write data", 32'(gen_dut[0].last_wr_data), 32'h1234);
    checkOutput("write keeps rdata", 32'({gen_dut[0].m0_rdata, gen_dut[0].m1_rdata}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
